// File: rtl/lzc_unit.sv
// lzc_unit: registered leading/trailing zero counter.
// The input is zero-padded to a power of two and scanned by a balanced binary
// tree of (valid, index) pairs. Leading mode bit-reverses the input first, so
// the tree always looks for the lowest set bit. The padding therefore always
// sits above the real bits and can never win the search.
module lzc_unit #(
  parameter int WIDTH = 2,
  parameter int MODE  = 0,
  localparam int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int PAD_WIDTH = 1 << CNT_WIDTH;

  // Elaboration-time parameter sanity checks
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "lzc_unit: WIDTH must be at least 1");
  end
  if ((MODE != 0) && (MODE != 1)) begin : g_bad_mode
    $fatal(1, "lzc_unit: MODE must be 0 (trailing) or 1 (leading)");
  end

  logic [PAD_WIDTH-1:0] scan_vec;
  logic                 root_valid;
  logic [CNT_WIDTH-1:0] root_idx;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 empty_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 empty_reg;

  // Build the padded scan vector; leading mode reverses bit order so that
  // position 0 of the scan corresponds to in_i[WIDTH-1].
  for (genvar gi = 0; gi < PAD_WIDTH; gi++) begin : g_scan
    if (gi >= WIDTH) begin : g_pad
      assign scan_vec[gi] = 1'b0;
    end else if (MODE == 1) begin : g_rev
      assign scan_vec[gi] = in_i[WIDTH-1-gi];
    end else begin : g_fwd
      assign scan_vec[gi] = in_i[gi];
    end
  end

  // Search tree: level 0 holds one leaf per scan bit, each level above halves
  // the node count. A node prefers its lower child, giving the lowest set index.
  for (genvar gi = 0; gi <= CNT_WIDTH; gi++) begin : g_lvl
    localparam int N = PAD_WIDTH >> gi;
    logic [N-1:0]         valid;
    logic [CNT_WIDTH-1:0] idx [N];

    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < N; gj++) begin : g_node
        assign valid[gj] = scan_vec[gj];
        assign idx[gj]   = CNT_WIDTH'(gj);
      end
    end else begin : g_merge
      for (genvar gj = 0; gj < N; gj++) begin : g_node
        assign valid[gj] = g_lvl[gi-1].valid[2*gj] | g_lvl[gi-1].valid[2*gj+1];
        assign idx[gj]   = g_lvl[gi-1].valid[2*gj] ? g_lvl[gi-1].idx[2*gj]
                                                   : g_lvl[gi-1].idx[2*gj+1];
      end
    end
  end

  assign root_valid = g_lvl[CNT_WIDTH].valid[0];
  assign root_idx   = g_lvl[CNT_WIDTH].idx[0];

  // Result to be registered: count forced to zero when nothing is set
  always_comb begin
    empty_next = ~root_valid;
    cnt_next   = root_valid ? root_idx : '0;
  end

  // Output registers; reset wins over the sampled input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg   <= '0;
      empty_reg <= 1'b1;
    end else begin
      cnt_reg   <= cnt_next;
      empty_reg <= empty_next;
    end
  end

  assign cnt_o   = cnt_reg;
  assign empty_o = empty_reg;

endmodule

// File: tb/tb_lzc_unit.sv
// tb_lzc_unit: directed table, exhaustive 8-bit sweep and randomized stream
// with reset pulses, across WIDTH=8/5/1 and both modes.
module tb_lzc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in8;
  logic [4:0] in5;
  logic       in1;

  logic [2:0] c8t, c8l, c5t, c5l;
  logic       e8t, e8l, e5t, e5l;
  logic [0:0] c1;
  logic       e1;

  lzc_unit #(.WIDTH(8), .MODE(0)) u_w8t (.clk_i(clk), .rst_i(rst), .in_i(in8), .cnt_o(c8t), .empty_o(e8t));
  lzc_unit #(.WIDTH(8), .MODE(1)) u_w8l (.clk_i(clk), .rst_i(rst), .in_i(in8), .cnt_o(c8l), .empty_o(e8l));
  lzc_unit #(.WIDTH(5), .MODE(0)) u_w5t (.clk_i(clk), .rst_i(rst), .in_i(in5), .cnt_o(c5t), .empty_o(e5t));
  lzc_unit #(.WIDTH(5), .MODE(1)) u_w5l (.clk_i(clk), .rst_i(rst), .in_i(in5), .cnt_o(c5l), .empty_o(e5l));
  lzc_unit #(.WIDTH(1), .MODE(0)) u_w1  (.clk_i(clk), .rst_i(rst), .in_i(in1), .cnt_o(c1),  .empty_o(e1));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [7:0] in8;
    logic [4:0] in5;
    logic       in1;
    int         c8t;
    int         c8l;
    logic       e8;
    int         c5t;
    int         c5l;
    logic       e5;
    logic       e1;
  } vec_t;

  vec_t tbl [10];

  // Reference: lowest set bit position via isolating it as a power of two
  function automatic int ref_tz(input int unsigned v);
    if (v == 0) return 0;
    return $clog2(v & (~v + 1));
  endfunction

  // Reference: width-1 minus floor(log2(v))
  function automatic int ref_lz(input int unsigned v, input int w);
    if (v == 0) return 0;
    return w - 1 - ($clog2(v + 1) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic verify(input string tag, input int x8t, input int x8l, input logic x8e,
                        input int x5t, input int x5l, input logic x5e, input logic x1e);
    chk({tag, " cnt w8 trailing"}, 32'(c8t), 32'(x8t));
    chk({tag, " empty w8 trailing"}, 32'(e8t), 32'(x8e));
    chk({tag, " cnt w8 leading"}, 32'(c8l), 32'(x8l));
    chk({tag, " empty w8 leading"}, 32'(e8l), 32'(x8e));
    chk({tag, " cnt w5 trailing"}, 32'(c5t), 32'(x5t));
    chk({tag, " empty w5 trailing"}, 32'(e5t), 32'(x5e));
    chk({tag, " cnt w5 leading"}, 32'(c5l), 32'(x5l));
    chk({tag, " empty w5 leading"}, 32'(e5l), 32'(x5e));
    chk({tag, " cnt w1"}, 32'(c1), 32'd0);
    chk({tag, " empty w1"}, 32'(e1), 32'(x1e));
    chk({tag, " range w5 trailing"}, 32'(c5t <= 3'd4), 32'd1);
    chk({tag, " range w5 leading"}, 32'(c5l <= 3'd4), 32'd1);
  endtask

  // Drive one sample, let it be captured on the next rising edge, then look
  task automatic step(input logic r, input logic [7:0] v8, input logic [4:0] v5, input logic v1);
    rst = r;
    in8 = v8;
    in5 = v5;
    in1 = v1;
    @(posedge clk);
    #1;
  endtask

  // Apply a sample and compare every instance against the reference model
  task automatic model_step(input string tag, input logic r, input logic [7:0] v8,
                            input logic [4:0] v5, input logic v1);
    step(r, v8, v5, v1);
    if (r)
      verify(tag, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1);
    else
      verify(tag, ref_tz(v8), ref_lz(v8, 8), (v8 == 0), ref_tz(v5), ref_lz(v5, 5),
             (v5 == 0), ~v1);
    $display("%s rst=%0b in8=%02h in5=%02h in1=%0b -> c8t=%0d c8l=%0d e8=%0b c5t=%0d c5l=%0d e5=%0b e1=%0b",
             tag, r, v8, v5, v1, c8t, c8l, e8t, c5t, c5l, e5t, e1);
  endtask

  initial begin
    rst = 1'b1;
    in8 = 8'hFF;
    in5 = 5'h1F;
    in1 = 1'b1;

    //            rst   in8    in5       in1  c8t c8l e8    c5t c5l e5    e1
    tbl[0] = '{1'b1, 8'hFF, 5'b11111, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 8'hFF, 5'b11111, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'hFF, 5'b11111, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h08, 5'b10000, 1'b1, 3, 4, 1'b0, 4, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h80, 5'b00001, 1'b0, 7, 0, 1'b0, 0, 4, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h01, 5'b00000, 1'b1, 0, 7, 1'b0, 0, 0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 5'b00100, 1'b0, 0, 0, 1'b1, 2, 2, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'h81, 5'b01010, 1'b1, 0, 0, 1'b0, 1, 1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 8'h5A, 5'b00110, 1'b1, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h5A, 5'b00110, 1'b1, 1, 1, 1'b0, 1, 2, 1'b0, 1'b0};

    // Directed table: back-to-back samples, reset hold and mid-stream reset
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].in8, tbl[i].in5, tbl[i].in1);
      verify($sformatf("table[%0d]", i), tbl[i].c8t, tbl[i].c8l, tbl[i].e8,
             tbl[i].c5t, tbl[i].c5l, tbl[i].e5, tbl[i].e1);
      $display("table[%0d] rst=%0b in8=%02h in5=%02h in1=%0b -> c8t=%0d c8l=%0d e8=%0b c5t=%0d c5l=%0d e5=%0b e1=%0b",
               i, tbl[i].rst, tbl[i].in8, tbl[i].in5, tbl[i].in1, c8t, c8l, e8t, c5t, c5l, e5t, e1);
    end

    // Hand sequence: steady input, one-cycle reset, result returns next edge
    model_step("hold", 1'b0, 8'h10, 5'b01000, 1'b1);
    model_step("hold_rst", 1'b1, 8'h10, 5'b01000, 1'b1);
    model_step("hold_resume", 1'b0, 8'h10, 5'b01000, 1'b1);

    // Exhaustive 8-bit sweep; narrower instances see the low bits
    for (int v = 0; v < 256; v++) begin
      logic [7:0] v8;
      v8 = 8'(v);
      model_step($sformatf("sweep[%0d]", v), 1'b0, v8, v8[4:0], v8[0]);
    end

    // Random stream with occasional single-cycle reset pulses
    for (int n = 0; n < 300; n++) begin
      logic       r;
      logic [7:0] v8;
      logic [4:0] v5;
      r  = ($urandom_range(0, 15) == 0);
      v8 = 8'($urandom_range(0, 255));
      v5 = 5'($urandom_range(0, 31));
      model_step($sformatf("rand[%0d]", n), r, v8, v5, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lzc_unit.md
Name: lzc_unit

Overview:
Registered leading/trailing zero counter. Takes a WIDTH-bit vector and reports how many zero bits precede the first set bit, counted from the LSB (trailing mode) or from the MSB (leading mode). It also reports whether the vector is all-zero. Round-robin arbiters use it to find the next requesting index above or below a priority pointer.

Parameters:
WIDTH, 2, width of in_i; legal range 1..1024; need not be a power of two.
MODE, 1'b0, 0 = count trailing zeros (from bit 0 upward); 1 = count leading zeros (from bit WIDTH-1 downward).
CNT_WIDTH, derived (WIDTH > 1 ? clog2(WIDTH) : 1), width of cnt_o; do not override.

Ports:
clk_i  input  1  clock, rising-edge.
rst_i  input  1  synchronous reset, active-high.
in_i  input  WIDTH  vector to scan.
cnt_o  output  CNT_WIDTH  registered zero count.
empty_o  output  1  registered flag: sampled in_i was all-zero.

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high. No other control inputs.
- Latency: exactly 1 cycle. in_i is sampled on every rising edge, and both outputs update on that same edge. No enable and no handshake; a new result is produced every cycle.
- Trailing mode (MODE=0):
  - cnt_o = index of the lowest set bit of in_i.
  - Examples: in_i=8'b0000_1000 -> 3; 8'b1000_0001 -> 0.
- Leading mode (MODE=1):
  - cnt_o = WIDTH-1 - index of the highest set bit of in_i.
  - Examples: in_i=8'b0000_1000 -> 4; 8'b1000_0001 -> 0.
- Empty input (in_i == 0): empty_o=1 and cnt_o=0.
- Any set bit: empty_o=0.
- Result is a pure function of the sampled in_i. Extra set bits beyond the first found are ignored.
- Non-power-of-two WIDTH: logic behaves as if in_i were zero-padded to 2**CNT_WIDTH bits.
  - In trailing mode the padding sits above the MSB.
  - In leading mode the count is still taken relative to bit WIDTH-1, so padding never contributes to the count.
  - cnt_o never exceeds WIDTH-1.
- WIDTH=1: cnt_o is always 0; empty_o = ~in_i[0].
- Reset: while rst_i=1 at a rising edge, cnt_o<=0 and empty_o<=1, regardless of in_i.
  - Reset has priority over sampling.
  - The first valid result appears on the edge after rst_i is deasserted.
- Reset asserted mid-stream discards the in-flight sample. No other state exists.
- Implementation: the combinational search is a log2 binary tree of (valid, index) pairs feeding the output registers.
  - A linear priority chain is not acceptable.
  - Depth must be CNT_WIDTH levels.
- Elaboration checks: WIDTH==0 is a fatal error; MODE outside {0,1} is a fatal error.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with in_i=8'hFF -> cnt_o=0, empty_o=1. Release rst_i; after one edge cnt_o=0, empty_o=0.
- Trailing mode, WIDTH=8:
  - Drive 8'h08, 8'h80, 8'h01, 8'h00 on consecutive cycles.
  - Outputs one cycle later: cnt 3/7/0/0 with empty 0/0/0/1.
  - Confirms back-to-back throughput.
- Leading mode, WIDTH=8: drive 8'h08, 8'h80, 8'h01, 8'h81 -> cnt_o 4, 0, 7, 0; empty_o=0 throughout.
- Non-power-of-two, WIDTH=5:
  - MODE=0: in_i=5'b10000 -> cnt_o=4.
  - MODE=1: in_i=5'b00001 -> cnt_o=4; in_i=5'b10000 -> cnt_o=0.
  - in_i=0 -> empty_o=1, cnt_o=0.
- Exhaustive check, WIDTH=8 both modes: sweep all 256 values of in_i and compare against a golden model, one cycle delayed.
  - Also assert empty_o == (in_i==0) and cnt_o <= WIDTH-1.
- Reset mid-stream:
  - Stream random in_i, assert rst_i for one cycle -> outputs forced to 0/1 on that edge.
  - Results resume correctly on the following edge.
  - WIDTH=1 case: in_i=1 -> cnt_o=0, empty_o=0; in_i=0 -> empty_o=1.
